pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 24 ++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 19 +
 rtl/pipe_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared widths, ctrl_state encodings and load-use detect
package pipe_hazard_ctrl_pkg;

    localparam int ISIZE   = 32;
    localparam int RADDR_W = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_MC_WAIT  = 2'd2
    } ctrl_state_t;

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    function automatic logic load_use_hit(
        input logic               is_load,
        input logic               rd_we,
        input logic [RADDR_W-1:0] rd,
        input logic [RADDR_W-1:0] rs1,
        input logic [RADDR_W-1:0] rs2
    );
        return is_load & rd_we & (rd != '0) & ((rd == rs1) | (rd == rs2));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// rtl/pipe_hazard_ctrl_sat_counter.sv - width-parameterised saturating incrementer, sync clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush controller; HAZ_MC_EN enables MC_WAIT and timeout
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int LOAD_LAT   = 1,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RADDR_W-1:0] id_rs1,
    input  logic [RADDR_W-1:0] id_rs2,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic               ex_rd_we,
    input  logic               ex_is_load,
    input  logic               branch_taken,
    input  logic               mc_start,
    input  logic               mc_done,
    output logic               pc_en,
    output logic               ifid_en,
    output logic               ifid_flush,
    output logic               idex_bubble,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic               mc_timeout,
    output logic [1:0]         ctrl_state
);

`ifdef HAZ_MC_EN
    localparam bit MC_EN = 1'b1;
`else
    localparam bit MC_EN = 1'b0;
`endif

    localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

    ctrl_state_t state, state_nxt;
    logic [2:0]    ld_cnt, ld_cnt_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          tmo_set;
    logic          load_use;

    assign load_use   = load_use_hit(ex_is_load, ex_rd_we, ex_rd, id_rs1, id_rs2);
    assign ctrl_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            ld_cnt     <= '0;
            timer      <= '0;
            mc_timeout <= 1'b0;
        end else begin
            state  <= state_nxt;
            ld_cnt <= ld_cnt_nxt;
            timer  <= timer_nxt;
            if (tmo_set) begin
                mc_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        ld_cnt_nxt  = ld_cnt;
        timer_nxt   = timer;
        tmo_set     = 1'b0;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        case (state)
            ST_RUN: begin
                if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (MC_EN && mc_start) begin
                    pc_en     = 1'b0;
                    ifid_en   = 1'b0;
                    state_nxt = ST_MC_WAIT;
                    timer_nxt = '0;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                    // the RUN cycle is the first stall cycle; LD_STALL covers the rest
                    if (LOAD_LAT > 1) begin
                        state_nxt  = ST_LD_STALL;
                        ld_cnt_nxt = 3'(LOAD_LAT - 1);
                    end
                end
            end
            ST_LD_STALL: begin
                if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    state_nxt   = ST_RUN;
                    ld_cnt_nxt  = '0;
                end else begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                    if (ld_cnt == 3'd1) begin
                        state_nxt  = ST_RUN;
                        ld_cnt_nxt = '0;
                    end else begin
                        ld_cnt_nxt = ld_cnt - 3'd1;
                    end
                end
            end
            ST_MC_WAIT: begin
                pc_en   = 1'b0;
                ifid_en = 1'b0;
                if (mc_done) begin
                    state_nxt = ST_RUN;
                end else if (timer == TW'(MC_TIMEOUT - 1)) begin
                    tmo_set   = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .inc (~pc_en),
        .q   (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench: vector table, corner sequences, random vs model
module tb_pipe_hazard_ctrl;

`ifdef HAZ_MC_EN
    localparam bit MC = 1'b1;
`else
    localparam bit MC = 1'b0;
`endif

    localparam int LL_A = 3, TO_A = 8,  CW_A = 16;
    localparam int LL_B = 1, TO_B = 64, CW_B = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic ex_rd_we = 1'b0, ex_is_load = 1'b0, branch_taken = 1'b0;
    logic mc_start = 1'b0, mc_done = 1'b0;

    logic a_pc, a_ifen, a_fl, a_bub, a_tmo;
    logic [1:0] a_st;
    logic [CW_A-1:0] a_cnt;
    logic b_pc, b_ifen, b_fl, b_bub, b_tmo;
    logic [1:0] b_st;
    logic [CW_B-1:0] b_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LOAD_LAT(LL_A), .MC_TIMEOUT(TO_A), .CNT_W(CW_A)) u_dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load), .branch_taken(branch_taken),
        .mc_start(mc_start), .mc_done(mc_done), .pc_en(a_pc), .ifid_en(a_ifen),
        .ifid_flush(a_fl), .idex_bubble(a_bub), .stall_cnt(a_cnt),
        .mc_timeout(a_tmo), .ctrl_state(a_st)
    );

    pipe_hazard_ctrl #(.LOAD_LAT(LL_B), .MC_TIMEOUT(TO_B), .CNT_W(CW_B)) u_sat (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load), .branch_taken(branch_taken),
        .mc_start(mc_start), .mc_done(mc_done), .pc_en(b_pc), .ifid_en(b_ifen),
        .ifid_flush(b_fl), .idex_bubble(b_bub), .stall_cnt(b_cnt),
        .mc_timeout(b_tmo), .ctrl_state(b_st)
    );

    typedef struct {
        logic       rst;
        logic [4:0] rs1, rs2, rd;
        logic       we, ld, br, ms, md;
    } in_t;

    typedef struct {
        in_t  i;
        bit   chk;
        bit   pc, ifen, fl, bub;
        int   st;
        int   cnt;
    } vec_t;

    typedef struct { int mode; int ld_left; int mc_el; bit tmo; int cnt; } mdl_t;
    typedef struct { bit pc; bit ifen; bit fl; bit bub; } out_t;

    vec_t tbl[$];

    function automatic in_t mi(logic r, logic [4:0] a, logic [4:0] b, logic [4:0] d,
                               logic we, logic ld, logic br, logic ms, logic md);
        in_t i;
        i.rst = r; i.rs1 = a; i.rs2 = b; i.rd = d;
        i.we = we; i.ld = ld; i.br = br; i.ms = ms; i.md = md;
        return i;
    endfunction

    task automatic addv(input in_t i, input bit c, input bit pc, input bit ifen,
                        input bit fl, input bit bub, input int st, input int cnt);
        vec_t v;
        v.i = i; v.chk = c; v.pc = pc; v.ifen = ifen; v.fl = fl; v.bub = bub;
        v.st = st; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic drive(input in_t i);
        @(negedge clk);
        rst = i.rst; id_rs1 = i.rs1; id_rs2 = i.rs2; ex_rd = i.rd;
        ex_rd_we = i.we; ex_is_load = i.ld; branch_taken = i.br;
        mc_start = i.ms; mc_done = i.md;
        #1;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit lu(in_t i);
        return i.ld && i.we && (i.rd != 0) && (i.rd == i.rs1 || i.rd == i.rs2);
    endfunction

    // mode: 0 running, 1 extra load-stall cycles pending, 2 waiting on multicycle unit
    function automatic out_t m_out(mdl_t m, in_t i);
        out_t o;
        o = '{1, 1, 0, 0};
        if (m.mode == 2)        o = '{0, 0, 0, 0};
        else if (i.br)          o = '{1, 1, 1, 1};
        else if (m.mode == 1)   o = '{0, 0, 0, 1};
        else if (MC && i.ms)    o = '{0, 0, 0, 0};
        else if (lu(i))         o = '{0, 0, 0, 1};
        return o;
    endfunction

    function automatic mdl_t m_next(mdl_t m, in_t i, int lat, int tmo_lim, int cmax);
        mdl_t n;
        out_t o;
        n = m;
        o = m_out(m, i);
        if (i.rst) return '{0, 0, 0, 0, 0};
        if (!o.pc && m.cnt < cmax) n.cnt = m.cnt + 1;
        if (m.mode == 2) begin
            if (i.md) n.mode = 0;
            else if (m.mc_el + 1 == tmo_lim) begin n.tmo = 1; n.mode = 0; end
            else n.mc_el = m.mc_el + 1;
        end else if (m.mode == 1) begin
            if (i.br) n.mode = 0;
            else begin
                n.ld_left = m.ld_left - 1;
                if (n.ld_left == 0) n.mode = 0;
            end
        end else begin
            if (i.br) n.mode = 0;
            else if (MC && i.ms) begin n.mode = 2; n.mc_el = 0; end
            else if (lu(i) && lat > 1) begin n.mode = 1; n.ld_left = lat - 1; end
        end
        return n;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t idle, rs, lu5, lu5br, ms, md, br;
        mdl_t ma, mb;
        out_t oa, ob;
        int n;
        idle  = mi(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rs    = mi(1, 0, 0, 0, 0, 0, 0, 0, 0);
        lu5   = mi(0, 0, 5, 5, 1, 1, 0, 0, 0);
        lu5br = mi(0, 0, 5, 5, 1, 1, 1, 0, 0);
        ms    = mi(0, 0, 0, 0, 0, 0, 0, 1, 0);
        md    = mi(0, 0, 0, 0, 0, 0, 0, 0, 1);
        br    = mi(0, 0, 0, 0, 0, 0, 1, 0, 0);

        // directed vectors against instance A (LOAD_LAT=3); stall_cnt is the value before the edge
        addv(rs,    0, 1, 1, 0, 0, 0, 0);
        addv(rs,    1, 1, 1, 0, 0, 0, 0);
        addv(idle,  1, 1, 1, 0, 0, 0, 0);
        addv(lu5,   1, 0, 0, 0, 1, 0, 0);
        addv(lu5,   1, 0, 0, 0, 1, 1, 1);
        addv(lu5,   1, 0, 0, 0, 1, 1, 2);
        addv(idle,  1, 1, 1, 0, 0, 0, 3);
        addv(mi(0, 0, 0, 0, 1, 1, 0, 0, 0), 1, 1, 1, 0, 0, 0, 3);
        addv(idle,  1, 1, 1, 0, 0, 0, 3);
        addv(lu5br, 1, 1, 1, 1, 1, 0, 3);
        addv(idle,  1, 1, 1, 0, 0, 0, 3);
        addv(mi(0, 7, 0, 7, 1, 1, 0, 0, 0), 1, 0, 0, 0, 1, 0, 3);
        addv(mi(0, 7, 0, 7, 1, 1, 1, 0, 0), 1, 1, 1, 1, 1, 1, 4);
        addv(idle,  1, 1, 1, 0, 0, 0, 4);
        addv(mi(0, 0, 5, 5, 0, 1, 0, 0, 0), 1, 1, 1, 0, 0, 0, 4);
        addv(mi(0, 5, 0, 5, 1, 0, 0, 0, 0), 1, 1, 1, 0, 0, 0, 4);
        if (MC) begin
            addv(ms,   1, 0, 0, 0, 0, 0, 4);
            addv(idle, 1, 0, 0, 0, 0, 2, 5);
            addv(br,   1, 0, 0, 0, 0, 2, 6);
            addv(md,   1, 0, 0, 0, 0, 2, 7);
            addv(idle, 1, 1, 1, 0, 0, 0, 8);
            addv(mi(1, 0, 5, 5, 1, 1, 0, 0, 0), 1, 0, 0, 0, 1, 0, 8);
        end else begin
            addv(ms,   1, 1, 1, 0, 0, 0, 4);
            addv(idle, 1, 1, 1, 0, 0, 0, 4);
            addv(br,   1, 1, 1, 1, 1, 0, 4);
            addv(md,   1, 1, 1, 0, 0, 0, 4);
            addv(idle, 1, 1, 1, 0, 0, 0, 4);
            addv(mi(1, 0, 5, 5, 1, 1, 0, 0, 0), 1, 0, 0, 0, 1, 0, 4);
        end
        addv(idle,  1, 1, 1, 0, 0, 0, 0);

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].i);
            if (tbl[k].chk) begin
                chk($sformatf("vec%0d_pc_en", k), a_pc, tbl[k].pc);
                if (!tbl[k].fl) chk($sformatf("vec%0d_ifid_en", k), a_ifen, tbl[k].ifen);
                chk($sformatf("vec%0d_ifid_flush", k), a_fl, tbl[k].fl);
                chk($sformatf("vec%0d_idex_bubble", k), a_bub, tbl[k].bub);
                chk($sformatf("vec%0d_ctrl_state", k), a_st, tbl[k].st);
                chk($sformatf("vec%0d_stall_cnt", k), a_cnt, tbl[k].cnt);
            end
        end

        // multicycle op completing on its 10th wait cycle (instance B, timeout 64)
        drive(rs); drive(rs);
        drive(ms);
        for (int k = 0; k < 9; k++) drive(idle);
        drive(md);
        drive(idle);
        chk("mc_done10_stall_cnt", b_cnt, MC ? 11 : 0);
        chk("mc_done10_timeout", b_tmo, 0);
        chk("mc_done10_state", b_st, 0);
        chk("mc_done10_a_timed_out", a_tmo, MC);

        // timeout after exactly TO_A wait cycles, flag sticky until reset
        drive(rs); drive(rs);
        chk("tmo_reset_clear", a_tmo, 0);
        drive(ms);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            drive(idle);
            if (a_st == 2) n++;
            else break;
        end
        chk("tmo_wait_cycles", n, MC ? TO_A : 0);
        chk("tmo_flag_set", a_tmo, MC);
        chk("tmo_state_run", a_st, 0);
        drive(ms); drive(md); drive(idle); drive(idle);
        chk("tmo_flag_sticky", a_tmo, MC);

        // reset in the middle of a wait aborts without flagging a timeout
        drive(rs); drive(idle);
        drive(ms); drive(idle); drive(idle);
        drive(rs);
        drive(idle);
        chk("abort_state_run", a_st, 0);
        chk("abort_no_timeout", a_tmo, 0);
        for (int k = 0; k < 12; k++) drive(idle);
        chk("abort_still_no_timeout", a_tmo, 0);

        // continuous load-use into the 4-bit counter of instance B
        drive(rs); drive(rs);
        for (int k = 0; k < 20; k++) begin
            drive(lu5);
            chk($sformatf("sat_cnt_%0d", k), b_cnt, (k < 15) ? k : 15);
        end
        drive(idle);
        chk("sat_cnt_final", b_cnt, 15);

        // randomized traffic against the reference model for both instances
        drive(rs);
        ma = '{0, 0, 0, 0, 0};
        mb = '{0, 0, 0, 0, 0};
        for (int k = 0; k < 3000; k++) begin
            in_t ri;
            ri.rst = ($urandom_range(0, 99) == 0);
            ri.rs1 = 5'($urandom_range(0, 3));
            ri.rs2 = 5'($urandom_range(0, 3));
            ri.rd  = 5'($urandom_range(0, 3));
            ri.we  = ($urandom_range(0, 3) != 0);
            ri.ld  = ($urandom_range(0, 2) != 0);
            ri.br  = ($urandom_range(0, 7) == 0);
            ri.ms  = ($urandom_range(0, 11) == 0);
            ri.md  = ($urandom_range(0, 9) == 0);
            drive(ri);
            oa = m_out(ma, ri);
            ob = m_out(mb, ri);
            chk("rnd_a_pc_en", a_pc, oa.pc);
            if (!oa.fl) chk("rnd_a_ifid_en", a_ifen, oa.ifen);
            chk("rnd_a_flush", a_fl, oa.fl);
            chk("rnd_a_bubble", a_bub, oa.bub);
            chk("rnd_a_state", a_st, ma.mode);
            chk("rnd_a_stall_cnt", a_cnt, ma.cnt);
            chk("rnd_a_timeout", a_tmo, ma.tmo);
            chk("rnd_b_pc_en", b_pc, ob.pc);
            if (!ob.fl) chk("rnd_b_ifid_en", b_ifen, ob.ifen);
            chk("rnd_b_flush", b_fl, ob.fl);
            chk("rnd_b_bubble", b_bub, ob.bub);
            chk("rnd_b_state", b_st, mb.mode);
            chk("rnd_b_stall_cnt", b_cnt, mb.cnt);
            chk("rnd_b_timeout", b_tmo, mb.tmo);
            ma = m_next(ma, ri, LL_A, TO_A, (1 << CW_A) - 1);
            mb = m_next(mb, ri, LL_B, TO_B, (1 << CW_B) - 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
